// File: rtl/clock_time_counter.sv
`default_nettype none
// ============================================================================
//  Module   : clock_time_counter
//  Purpose  : Time-of-day counter (hundredths/seconds/minutes/hours, BCD)
//             advanced by ticks taken from a synchronised 100 Hz square wave,
//             with clear and manual minute/hour set.
//  Revision : 1.0 - initial release
// ============================================================================
module clock_time_counter #(
  parameter int MAX_HOUR = 24
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_clk_100hz,
  input  logic       i_run,
  input  logic       i_clear,
  input  logic       i_inc_min,
  input  logic       i_inc_hour,
  output logic [7:0] o_csec,
  output logic [7:0] o_sec,
  output logic [7:0] o_min,
  output logic [7:0] o_hour,
  output logic       o_sec_tick
);

  // Last legal hour value expressed as a BCD pair {tens, units}.
  localparam logic [7:0] c_HOUR_LAST =
    8'((((MAX_HOUR - 1) / 10) * 16) + ((MAX_HOUR - 1) % 10));

  // Advance a BCD pair by one, wrapping to 00 after 'last'. Units roll
  // 9 -> 0 with a tens increment, so digits always stay inside 0..9.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v,
                                         input logic [7:0] last);
    logic [7:0] r;
    if (v == last)
      r = 8'h00;
    else if (v[3:0] == 4'd9)
      r = {v[7:4] + 4'd1, 4'd0};
    else
      r = {v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

  logic       r_s1;
  logic       r_s2;
  logic       r_s2_d;
  logic [7:0] r_csec;
  logic [7:0] r_sec;
  logic [7:0] r_min;
  logic [7:0] r_hour;
  logic       r_sec_tick;

  logic       w_tick;
  logic       w_count;
  logic       w_csec_wrap;
  logic       w_sec_wrap;
  logic       w_min_wrap;

  // The divided clock is only data: one tick per synchronised rising edge.
  assign w_tick      = r_s2 & ~r_s2_d;
  assign w_count     = i_run & w_tick;
  assign w_csec_wrap = (r_csec == 8'h99);
  assign w_sec_wrap  = (r_sec  == 8'h59);
  assign w_min_wrap  = (r_min  == 8'h59);

  // Two-flop synchroniser plus a delayed copy for rising-edge detection.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1   <= 1'b0;
      r_s2   <= 1'b0;
      r_s2_d <= 1'b0;
    end else begin
      r_s1   <= i_clk_100hz;
      r_s2   <= r_s1;
      r_s2_d <= r_s2;
    end
  end

  // Time chain: clear beats counting; manual set only applies while frozen.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_csec     <= 8'h00;
      r_sec      <= 8'h00;
      r_min      <= 8'h00;
      r_hour     <= 8'h00;
      r_sec_tick <= 1'b0;
    end else if (i_clear) begin
      r_csec     <= 8'h00;
      r_sec      <= 8'h00;
      r_min      <= 8'h00;
      r_hour     <= 8'h00;
      r_sec_tick <= 1'b0;
    end else begin
      r_sec_tick <= 1'b0;
      if (w_count) begin
        r_csec <= bcd_inc(r_csec, 8'h99);
        // Seconds only move when hundredths wrap, so that is the tick point.
        if (w_csec_wrap) begin
          r_sec      <= bcd_inc(r_sec, 8'h59);
          r_sec_tick <= 1'b1;
          if (w_sec_wrap) begin
            r_min <= bcd_inc(r_min, 8'h59);
            if (w_min_wrap)
              r_hour <= bcd_inc(r_hour, c_HOUR_LAST);
          end
        end
      end else if (!i_run) begin
        // Minute set wraps on its own; it never carries into the hour.
        if (i_inc_min)
          r_min <= bcd_inc(r_min, 8'h59);
        if (i_inc_hour)
          r_hour <= bcd_inc(r_hour, c_HOUR_LAST);
      end
    end
  end

  assign o_csec     = r_csec;
  assign o_sec      = r_sec;
  assign o_min      = r_min;
  assign o_hour     = r_hour;
  assign o_sec_tick = r_sec_tick;

endmodule
`default_nettype wire

// File: doc/clock_time_counter.md
# clock_time_counter

Time-of-day counter fed by the 100 Hz divider output. It synchronises the divided square wave into the system clock domain and turns each rising edge into a single-cycle tick. That tick advances a BCD hundredths/seconds/minutes/hours chain, which can be cleared and hand-set. Outputs drive the display mux/7-segment stage directly; the divided clock is never used as a clock.

## Interface
- MAX_HOUR, 24: hour modulus; legal 1..24; hours count 00..MAX_HOUR-1.
- i_clk  in  1  system clock (100 MHz); all state on posedge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_clk_100hz  in  1  100 Hz square wave from divider, treated as asynchronous data.
- i_run  in  1  level; 1 = time advances on ticks, 0 = frozen/set mode.
- i_clear  in  1  single-cycle pulse; zeroes all counters.
- i_inc_min  in  1  single-cycle pulse (pre-debounced); minute +1.
- i_inc_hour  in  1  single-cycle pulse (pre-debounced); hour +1.
- o_csec  out  8  BCD hundredths {tens,units}, 00..99.
- o_sec  out  8  BCD seconds, 00..59.
- o_min  out  8  BCD minutes, 00..59.
- o_hour  out  8  BCD hours, 00..MAX_HOUR-1.
- o_sec_tick  out  1  one-cycle pulse, high in the cycle after o_sec changes due to counting.

## Operation
- Sync: 2-flop synchroniser (s1, s2) plus delayed copy s2_d; tick = s2 & ~s2_d. All three flops reset to 0.
- Priority per cycle: i_clear > counting > manual increments.
- i_clear: all four counters to 00 at next edge regardless of i_run; a coincident tick or inc is discarded.
- Counting (i_run=1, tick=1): csec +1; csec 99->00 carries to sec; sec 59->00 carries to min; min 59->00 carries to hour; hour MAX_HOUR-1 -> 00. Full wrap (e.g. 23:59:59.99) yields 00:00:00.00.
- Tick with i_run=0 is dropped (not queued).
- Manual set only when i_run=0; i_inc_min/i_inc_hour ignored while running.
- i_inc_min: min +1, 59->00, no carry into hour; sec/csec unchanged.
- i_inc_hour: hour +1, MAX_HOUR-1 -> 00.
- Both inc pulses in one cycle: both apply.
- Each BCD digit pair held as two 4-bit digits; digit values never leave 0..9. Tens digit limits: csec 9, sec/min 5; hour compares the full pair against MAX_HOUR-1.
- o_sec_tick: registered; asserted for exactly one cycle after every counting-induced sec change, including 59->00. Not asserted for clear or manual set.

## Timing
- Reset (async assert): o_csec=o_sec=o_min=o_hour=8'h00, o_sec_tick=0, s1=s2=s2_d=0, effective immediately; mid-operation reset discards all state.
- Latency: the first i_clk edge sampling i_clk_100hz=1 is E1. s2 rises at E2, and counters update at E3. o_sec_tick is high E3..E4 when the sec value changes.
- If i_clk_100hz is already high at reset release, one tick is generated 3 edges after release (defined, accepted).
- Exactly one tick per input rising edge; input high time (~500k cycles) ≫ sync depth, so no missed/double ticks.
- Control inputs i_clear/i_inc_* act at the next edge (1-cycle latency).

## Test plan
- Reset release, i_run=1, 100 input rising edges -> o_csec 00->99->00, o_sec=8'h01, exactly one o_sec_tick pulse, each update 3 edges after input rise.
- Preload 23:59:59.99 via incs + ticks, one more tick -> 00:00:00.00, o_sec_tick=1 for one cycle; repeat with MAX_HOUR=12 from 11:59:59.99 -> 00:00:00.00.
- i_run=0, 5 input edges -> counters frozen; i_inc_min x61 from 00 -> o_min=8'h01, o_hour unchanged; i_inc_hour with i_run=1 -> no change.
- i_clear coincident with tick and i_inc_hour at 12:34:56.78 -> all 00 next edge, no o_sec_tick.
- Async i_rst_n low mid-count (between E2 and E3) -> outputs 00 immediately, no residual tick after release while input low.
- i_inc_min and i_inc_hour same cycle at 05:59 (i_run=0) -> 06:00? No: -> hour 06, min 00, no carry beyond that (min wrap does not add a second hour).
